// File: rtl/comp4_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the FSM state encoding, the running-relation codes, the bit
// positions of the relation output vector r, and the relation-to-r mapping.
package comp4_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Running relation of a versus b, narrowed one bit pair at a time.
  typedef enum logic [1:0] {
    REL_LT = 2'd0,
    REL_EQ = 2'd1,
    REL_GT = 2'd2
  } rel_e;

  // Bit positions inside the 4-bit relation vector r.
  localparam int unsigned R_LT_IDX = 0;
  localparam int unsigned R_EQ_IDX = 1;
  localparam int unsigned R_GT_IDX = 2;
  localparam int unsigned R_NE_IDX = 3;

  // Expand a relation code into the parallel comparator's output vector.
  // The unused code 2'd3 can never be produced; it maps to EQ.
  function automatic logic [3:0] rel_to_r(input logic [1:0] rel);
    logic [3:0] vec;
    vec = 4'b0000;
    case (rel)
      REL_LT: begin
        vec[R_LT_IDX] = 1'b1;
        vec[R_NE_IDX] = 1'b1;
      end
      REL_GT: begin
        vec[R_GT_IDX] = 1'b1;
        vec[R_NE_IDX] = 1'b1;
      end
      default: begin
        vec[R_EQ_IDX] = 1'b1;
      end
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/comp4_serial_bit_step.sv
// comp_bit_step: combinational per-bit relation update.
// Ports:
//   rel_in   current running relation (REL_LT / REL_EQ / REL_GT)
//   a_bit    serial bit of operand a
//   b_bit    serial bit of operand b
//   rel_out  relation after folding in this bit pair
// Parameter MSB_FIRST selects the update rule:
//   1: the first differing pair decides; later pairs cannot change a decided relation.
//   0: each differing pair overrides, since a more significant bit arrives later.
module comp_bit_step
  import comp4_serial_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [1:0] rel_in,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic [1:0] rel_out
);

  always_comb begin
    rel_out = rel_in;
    if (a_bit != b_bit) begin
      if (!MSB_FIRST || (rel_in == REL_EQ)) begin
        rel_out = a_bit ? REL_GT : REL_LT;
      end
    end
  end

endmodule

// File: rtl/comp4_serial.sv
// comp4_serial: bit-serial magnitude comparator.
// Consumes one (a_bit, b_bit) pair per cycle with bit_valid high and, after the
// WIDTH-th pair, reports the same relation vector a parallel comparator would.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a comparison (accepted in IDLE only)
//   bit_valid  a_bit/b_bit carry a valid pair this cycle
//   a_bit      serial bit of operand a
//   b_bit      serial bit of operand b
//   busy       high from start acceptance until the done cycle
//   done       one-cycle pulse; r updates in the same cycle
//   r          {a!=b, a>b, a==b, a<b}, held until the next done or reset
module comp4_serial
  import comp4_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       busy,
  output logic       done,
  output logic [3:0] r
);

  // One extra bit so the counter cannot wrap before the terminal count.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("comp4_serial: WIDTH must be in 2..16");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       rel_q;
  logic [1:0]       rel_next;

  comp_bit_step #(
    .MSB_FIRST(MSB_FIRST)
  ) u_step (
    .rel_in (rel_q),
    .a_bit  (a_bit),
    .b_bit  (b_bit),
    .rel_out(rel_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= REL_EQ;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          // bit_valid is ignored here, even in the same cycle as start.
          if (start) begin
            state_q <= SHIFT;
            busy    <= 1'b1;
            cnt_q   <= '0;
            rel_q   <= REL_EQ;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            rel_q <= rel_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              // Final pair: publish the relation including this pair directly.
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              r       <= rel_to_r(rel_next);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp4_serial.sv
// Testbench for comp4_serial: one instance per bit order, a directed vector
// table, hand-written corner sequences, and a randomized-stall sweep of all
// operand pairs against an arithmetic reference model.
module tb_comp4_serial;

  logic       clk;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] bv;
  logic [1:0] ab;
  logic [1:0] bb;
  logic [1:0] busy;
  logic [1:0] done;
  logic [3:0] r_m;
  logic [3:0] r_l;

  int checks = 0;
  int errors = 0;

  int         dn_cnt;
  int         dn_cyc;
  logic [3:0] dn_r;

  // Index 0: MSB first; index 1: LSB first.
  comp4_serial #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bit_valid(bv[0]),
    .a_bit(ab[0]), .b_bit(bb[0]), .busy(busy[0]), .done(done[0]), .r(r_m)
  );

  comp4_serial #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bit_valid(bv[1]),
    .a_bit(ab[1]), .b_bit(bb[1]), .busy(busy[1]), .done(done[1]), .r(r_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [3:0] a;
    logic [3:0] b;
    int         st_at;
    int         st_len;
    bit         xstart;
    logic [3:0] exp_r;
    int         exp_cyc;
  } vec_t;

  // Relation vector straight from arithmetic comparison.
  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
    return {a != b, a > b, a == b, a < b};
  endfunction

  function automatic logic [3:0] rsel(input int d);
    return (d == 0) ? r_m : r_l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poll(input int d, input int cyc);
    if (done[d]) begin
      dn_cnt++;
      dn_cyc = cyc;
      dn_r   = rsel(d);
    end
  endtask

  // One comparison. Start is raised together with a junk valid bit pair that must
  // not be consumed. st_at: bit index before which st_len stall cycles go (4 = none).
  // xstart: pulse start again during the second bit.
  task automatic run(input int d, input logic [3:0] a, input logic [3:0] b,
                     input int st_at, input int st_len, input bit xstart);
    int cyc;
    int idx;
    dn_cnt = 0;
    dn_cyc = -1;
    dn_r   = 4'b0000;
    start[d] = 1'b1;
    bv[d]    = 1'b1;
    ab[d]    = 1'($urandom);
    bb[d]    = 1'($urandom);
    tick();
    cyc = 1;
    start[d] = 1'b0;
    poll(d, cyc);
    for (int i = 0; i < 4; i++) begin
      if (i == st_at) begin
        for (int s = 0; s < st_len; s++) begin
          bv[d] = 1'b0;
          ab[d] = 1'($urandom);
          bb[d] = 1'($urandom);
          tick();
          cyc++;
          poll(d, cyc);
        end
      end
      idx = (d == 0) ? 3 - i : i;
      bv[d]    = 1'b1;
      ab[d]    = a[idx];
      bb[d]    = b[idx];
      start[d] = xstart && (i == 1);
      tick();
      cyc++;
      poll(d, cyc);
    end
    bv[d]    = 1'b0;
    start[d] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cyc++;
      poll(d, cyc);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int         exp_cyc;
    int         sa;
    int         sl;
    logic [3:0] va;
    logic [3:0] vb;

    vecs[0] = '{0, 4'd3,  4'd10, 4, 0, 1'b0, 4'b1001, 5};
    vecs[1] = '{0, 4'd15, 4'd14, 2, 2, 1'b0, 4'b1100, 7};
    vecs[2] = '{0, 4'd15, 4'd15, 4, 0, 1'b0, 4'b0010, 5};
    vecs[3] = '{1, 4'd8,  4'd5,  4, 0, 1'b0, 4'b1100, 5};
    vecs[4] = '{0, 4'd5,  4'd9,  4, 0, 1'b1, 4'b1001, 5};

    rst_n = 1'b0;
    start = 2'b00;
    bv    = 2'b00;
    ab    = 2'b00;
    bb    = 2'b00;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_r_msb", 32'(r_m), 32'd0);
    chk("reset_r_lsb", 32'(r_l), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      run(vecs[v].d, vecs[v].a, vecs[v].b, vecs[v].st_at, vecs[v].st_len, vecs[v].xstart);
      chk($sformatf("vec%0d_r", v), 32'(dn_r), 32'(vecs[v].exp_r));
      chk($sformatf("vec%0d_done_cycle", v), 32'(dn_cyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("vec%0d_done_count", v), 32'(dn_cnt), 32'd1);
      chk($sformatf("vec%0d_r_hold", v), 32'(rsel(vecs[v].d)), 32'(vecs[v].exp_r));
    end

    // Reset in the middle of SHIFT: a=12, b=3, MSB first, after two bits.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    va = 4'd12;
    vb = 4'd3;
    for (int i = 0; i < 2; i++) begin
      bv[0] = 1'b1;
      ab[0] = va[3 - i];
      bb[0] = vb[3 - i];
      tick();
    end
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy[0]), 32'd0);
    chk("async_reset_r", 32'(r_m), 32'd0);
    chk("async_reset_done", 32'(done[0]), 32'd0);
    bv[0] = 1'b0;
    tick();
    tick();
    chk("reset_no_done", 32'(done[0]), 32'd0);
    rst_n = 1'b1;
    tick();
    run(0, 4'd1, 4'd1, 4, 0, 1'b0);
    chk("post_reset_r", 32'(dn_r), 32'b0010);
    chk("post_reset_done_count", 32'(dn_cnt), 32'd1);

    // Start held through the DONE cycle: only the following IDLE cycle accepts it.
    va = 4'd5;
    vb = 4'd9;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("hold_busy_c1", 32'(busy[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bv[0]    = 1'b1;
      ab[0]    = va[3 - i];
      bb[0]    = vb[3 - i];
      start[0] = (i == 1) || (i == 3);
      tick();
      if (i < 3) begin
        chk($sformatf("hold_busy_bit%0d", i), 32'(busy[0]), 32'd1);
        chk($sformatf("hold_nodone_bit%0d", i), 32'(done[0]), 32'd0);
      end
    end
    bv[0] = 1'b0;
    chk("hold_done_c5", 32'(done[0]), 32'd1);
    chk("hold_r_c5", 32'(r_m), 32'b1001);
    chk("hold_busy_c5", 32'(busy[0]), 32'd0);
    tick();
    chk("hold_done_c6", 32'(done[0]), 32'd0);
    chk("hold_busy_c6", 32'(busy[0]), 32'd0);
    tick();
    chk("hold_accept_c7", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bv[0] = 1'b1;
      ab[0] = 1'b0;
      bb[0] = 1'b0;
      tick();
    end
    bv[0] = 1'b0;
    chk("hold_second_done", 32'(done[0]), 32'd1);
    chk("hold_second_r", 32'(r_m), 32'b0010);
    tick();
    chk("hold_second_pulse", 32'(done[0]), 32'd0);
    tick();

    // Full sweep of operand pairs in both bit orders with random stalls/restarts.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sa = int'($urandom_range(0, 4));
          sl = int'($urandom_range(0, 2));
          exp_cyc = (sa < 4) ? 5 + sl : 5;
          run(d, 4'(a), 4'(b), sa, sl, 1'($urandom));
          chk($sformatf("sweep_d%0d_a%0d_b%0d_r", d, a, b), 32'(dn_r),
              32'(ref_r(4'(a), 4'(b))));
          chk($sformatf("sweep_d%0d_a%0d_b%0d_cyc", d, a, b), 32'(dn_cyc), 32'(exp_cyc));
          chk($sformatf("sweep_d%0d_a%0d_b%0d_cnt", d, a, b), 32'(dn_cnt), 32'd1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp4_serial.md
Name: comp4_serial

Overview:
- Bit-serial 4-bit magnitude comparator.
- Consumes operands a and b one bit pair per clock, in the bit order set by a parameter.
- After the last bit it produces the same 4-bit relation vector as the parallel comparator.
- Used where operands arrive over serial links, so a parallel register plus compare is not needed at the receiving end.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- MSB_FIRST, 1: 1 means bits arrive MSB first; 0 means LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a comparison; accepted only in IDLE.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  serial bit of operand a.
- b_bit  input  1  serial bit of operand b.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse; r is updated in the same cycle.
- r  output  4  relation: r[0]=a<b, r[1]=a==b, r[2]=a>b, r[3]=a!=b.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, r=4'b0000, bit counter=0, relation register=EQ.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT; busy=1 next cycle; counter=0; relation register=EQ.
  - bit_valid in IDLE is ignored.
- SHIFT:
  - Each cycle with bit_valid=1 consumes one bit pair and increments the counter.
  - bit_valid=0 stalls; state and counter hold.
- MSB_FIRST=1: the relation register changes only while it is EQ.
  - First differing pair sets GT if a_bit=1/b_bit=0, else LT.
  - Later bits are consumed but ignored.
- MSB_FIRST=0: every differing pair overwrites the relation (GT or LT); equal pairs leave it unchanged.
- When the WIDTH-th pair is consumed -> DONE.
- DONE (one cycle):
  - done=1; r loaded from the final relation, including the last bit.
  - busy=0 in that same cycle; next state IDLE.
- r encoding:
  - LT -> 4'b1001.
  - EQ -> 4'b0010.
  - GT -> 4'b1100.
- r holds its value until the next DONE or reset.
- Latency: done asserts exactly one cycle after the cycle carrying the WIDTH-th valid pair. Minimum start-to-done is WIDTH+1 cycles with no stalls.
- start while busy=1 or in DONE is ignored; no restart or abort.
- start asserted in the DONE cycle is not accepted; earliest next accept is the following IDLE cycle.
- start and bit_valid high in the same IDLE cycle: the bit is not consumed; the first bit is taken the next cycle.
- Reset mid-SHIFT: immediate return to IDLE, r cleared to 0, no done pulse.
- Counter width is clog2(WIDTH)+1 so it cannot wrap before the terminal count.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - relation codes REL_LT=2'd0, REL_EQ=2'd1, REL_GT=2'd2;
  - the four r bit indices.
- One natural sub-module, comp_bit_step: combinational step function taking (rel_in, a_bit, b_bit, MSB_FIRST) and returning rel_out. It makes the per-bit rule unit-testable.
- The FSM, counter and output register stay in comp4_serial.

Test Plan:
- MSB_FIRST=1, start, then bits of a=3, b=10 with no stalls -> done at cycle 5 after start, r=4'b1001.
- MSB_FIRST=1, a=15, b=14, bit_valid low for 2 cycles after the 2nd bit -> done 2 cycles later than the no-stall case, r=4'b1100. Also a=15, b=15 -> r=4'b0010.
- MSB_FIRST=0, a=8, b=5 (LSB first: 0/1, 0/0, 0/1, 1/0) -> intermediate relation LT, final r=4'b1100.
- start pulsed again during SHIFT of a=5, b=9, and start held high through the DONE cycle -> neither is accepted; exactly one done; r=4'b1001; the next accept occurs in the following IDLE cycle.
- rst_n driven low after the 2nd bit of a=12, b=3 -> busy=0, r=0 immediately with no clock edge needed, no done pulse. Then a fresh a=1, b=1 run -> r=4'b0010.
- Sweep all 256 (a,b) pairs in both bit orders against a reference model -> r matches every time, with exactly one done per start.
